spi_txn_sequencer: RTL
======================

Name: spi_txn_sequencer

Overview:
- Command-queueing stage directly upstream of the SPI controller/memory subsystem.
- Accepts read/write commands from a host over a valid/ready interface and buffers them in a small FIFO.
- Issues commands one at a time on the controller's write_en/addr/data_in side, then waits for done/error with a timeout.
- Returns one response (read data plus status) per command over a second valid/ready interface.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2).
- TIMEOUT, 1024, max cycles ctl_req may stay high without ctl_done.
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_write  out  1  echo of command type.
- rsp_addr  out  ADDR_W  echo of command address.
- rsp_rdata  out  DATA_W  read data (0 for writes or failures).
- rsp_status  out  2  00=OK, 01=ERROR, 10=TIMEOUT.
- ctl_req  out  1  transaction request to controller, held until done.
- ctl_write_en  out  1  controller write_en.
- ctl_addr  out  ADDR_W  controller addr.
- ctl_data_in  out  DATA_W  controller data_in.
- ctl_done  in  1  controller done pulse.
- ctl_error  in  1  controller error, sampled with ctl_done.
- ctl_data_out  in  DATA_W  controller read data, sampled with ctl_done.
- busy  out  1  FSM not IDLE or FIFO not empty.
- fifo_count  out  $clog2(DEPTH+1)  entries queued.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - FIFO emptied and FSM to IDLE.
  - ctl_req, ctl_write_en, ctl_addr, ctl_data_in, rsp_* all driven 0; busy=0; fifo_count=0.
  - cmd_ready=0 while rst is high, otherwise cmd_ready = (fifo_count < DEPTH).
  - Reset mid-transaction abandons the transaction without a response; ctl_req is low the cycle after the reset edge.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only in IDLE when not empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Full: cmd_ready=0 even if a pop occurs that cycle (no combinational pop→ready path).
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop the head into the transaction registers (write, addr, wdata) and go to ISSUE. Otherwise stay.
  - ISSUE:
    - ctl_req=1; ctl_write_en/ctl_addr/ctl_data_in driven from the transaction registers, stable for the whole state. Timeout counter increments each cycle.
    - On ctl_done: status = ctl_error ? ERROR : OK; rdata = (read && !ctl_error) ? ctl_data_out : 0; go to RESP.
    - Otherwise, when the counter reaches TIMEOUT-1: status=TIMEOUT, rdata=0, go to RESP.
    - ctl_done on the timeout cycle counts as done (done wins).
  - RESP: ctl_req=0; rsp_valid=1 with rsp_* stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and clear the counter.
- ctl_done/ctl_error seen outside ISSUE are ignored (late done after a timeout is dropped).
- Latency:
  - Command accepted at edge N into an empty FIFO with the FSM in IDLE: ctl_req high after edge N+2.
  - ctl_done high at edge E: rsp_valid high and ctl_req low after edge E.
  - ctl_req is low for at least 2 cycles (RESP + IDLE) between back-to-back transactions.
- Ordering: responses are returned strictly in command order, one per command; no reordering or merging.

Decomposition:
- Package spi_seq_pkg:
  - state enum {IDLE, ISSUE, RESP}.
  - status enum {ST_OK=2'b00, ST_ERROR=2'b01, ST_TIMEOUT=2'b10}.
  - packed struct spi_cmd_t {write, addr, wdata}.
- Sub-module spi_cmd_fifo: synchronous FIFO of spi_cmd_t with DEPTH parameter, push/pop/full/empty/count.

Test Plan:
- Read: cmd read addr=0x10 while the controller model returns done at cycle +5 with data_out=0xA5, error=0. Expect ctl_req high 2 cycles after accept, then rsp {write=0, addr=0x10, rdata=0xA5, status=00}.
- Write then read: write 0x3C to addr 0x22, then read addr 0x22 using a memory-backed controller model. Expect responses in order: {1, 0x22, 0x00, 00}, then {0, 0x22, 0x3C, 00}.
- Fill and back-pressure: DEPTH=4 with the controller stalled and 6 commands offered. Expect cmd_ready=0 once fifo_count=4 (4 queued, 1 in flight). With rsp_ready=0, rsp_valid holds steady and no new ctl_req appears.
- Error and timeout:
  - ctl_done with ctl_error=1 on a read → status 01, rdata 0x00.
  - No ctl_done for TIMEOUT=16 cycles → status 10, ctl_req low.
  - A late ctl_done arriving afterwards is ignored.
- Done on timeout cycle: ctl_done asserted exactly at counter TIMEOUT-1 → status 00, not 10.
- Reset mid-ISSUE: rst high for 1 cycle with 3 commands queued. Expect ctl_req=0, fifo_count=0, no response, and cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types for the SPI transaction sequencer
// FSM states, response status codes and the queued command record.
package spi_seq_pkg;

  localparam int SEQ_ADDR_W = 8;
  localparam int SEQ_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERROR   = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_t;

  typedef struct packed {
    logic                  write;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [SEQ_DATA_W-1:0] wdata;
  } spi_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// rtl/spi_cmd_fifo.sv - synchronous command FIFO of spi_cmd_t
// Head entry is presented combinationally on rd_data; count is registered.
module spi_cmd_fifo
  import spi_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  spi_cmd_t                   wr_data,
  output spi_cmd_t                   rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  spi_cmd_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// rtl/spi_txn_sequencer.sv - queues host commands and sequences them to the SPI controller
// One command in flight at a time, with done/error/timeout folded into an in-order response.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = SEQ_ADDR_W,
  parameter int DATA_W  = SEQ_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [ADDR_W-1:0]          rsp_addr,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                 rsp_status,
  output logic                       ctl_req,
  output logic                       ctl_write_en,
  output logic [ADDR_W-1:0]          ctl_addr,
  output logic [DATA_W-1:0]          ctl_data_in,
  input  logic                       ctl_done,
  input  logic                       ctl_error,
  input  logic [DATA_W-1:0]          ctl_data_out,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT+1);

  state_t         state;
  spi_cmd_t       txn;
  spi_cmd_t       head;
  spi_cmd_t       incoming;
  logic [TW-1:0]  timer;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;

  assign incoming.write = cmd_write;
  assign incoming.addr  = cmd_addr;
  assign incoming.wdata = cmd_wdata;

  assign ctl_write_en = txn.write;
  assign ctl_addr     = txn.addr;
  assign ctl_data_in  = txn.wdata;

  spi_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (incoming),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // ctl_req is registered, so it rises one cycle into ISSUE; done on the
  // final timeout cycle takes priority over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txn        <= '0;
      timer      <= '0;
      ctl_req    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_addr   <= '0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            txn   <= head;
            timer <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ctl_done) begin
            ctl_req    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= txn.write;
            rsp_addr   <= txn.addr;
            rsp_status <= ctl_error ? ST_ERROR : ST_OK;
            rsp_rdata  <= (!txn.write && !ctl_error) ? ctl_data_out : '0;
            state      <= RESP;
          end else if (timer == TW'(TIMEOUT-1)) begin
            ctl_req    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= txn.write;
            rsp_addr   <= txn.addr;
            rsp_status <= ST_TIMEOUT;
            rsp_rdata  <= '0;
            state      <= RESP;
          end else begin
            ctl_req <= 1'b1;
            timer   <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_addr   <= '0;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
            timer      <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
